// File: rtl/e203_lsu_agu_icb_align.sv
// LSU alignment stage between the AGU ICB and the memory ICB: lane-replicates store data,
// builds byte masks, tracks outstanding transactions in order and aligns/extends load data.
module e203_lsu_agu_icb_align #(
   parameter int unsigned OUTS_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        agu_icb_cmd_valid,
   output logic        agu_icb_cmd_ready,
   input  logic [31:0] agu_icb_cmd_addr,
   input  logic        agu_icb_cmd_read,
   input  logic [31:0] agu_icb_cmd_wdata,
   input  logic [1:0]  agu_icb_cmd_size,
   input  logic        agu_icb_cmd_usign,
   input  logic        agu_icb_cmd_itag,

   output logic        agu_icb_rsp_valid,
   input  logic        agu_icb_rsp_ready,
   output logic        agu_icb_rsp_err,
   output logic [31:0] agu_icb_rsp_rdata,
   output logic        agu_icb_rsp_itag,

   output logic        mem_icb_cmd_valid,
   input  logic        mem_icb_cmd_ready,
   output logic [31:0] mem_icb_cmd_addr,
   output logic        mem_icb_cmd_read,
   output logic [31:0] mem_icb_cmd_wdata,
   output logic [3:0]  mem_icb_cmd_wmask,

   input  logic        mem_icb_rsp_valid,
   output logic        mem_icb_rsp_ready,
   input  logic        mem_icb_rsp_err,
   input  logic [31:0] mem_icb_rsp_rdata,

   output logic        outs_empty
);

   localparam int unsigned PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
   localparam int unsigned CW = $clog2(OUTS_DEPTH + 1);

   typedef struct packed {
      logic [1:0] addr;
      logic [1:0] size;
      logic       usign;
      logic       read;
      logic       itag;
   } ent_t;

   ent_t          ent_q [OUTS_DEPTH];
   ent_t          head;
   logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          full, empty, push, pop;

   assign full  = (cnt_q == CW'(OUTS_DEPTH));
   assign empty = (cnt_q == '0);

   // No bypass: a pop in the same cycle does not free a slot for the incoming command.
   assign mem_icb_cmd_valid = agu_icb_cmd_valid & ~full;
   assign agu_icb_cmd_ready = mem_icb_cmd_ready & ~full;
   assign mem_icb_cmd_addr  = agu_icb_cmd_addr;
   assign mem_icb_cmd_read  = agu_icb_cmd_read;

   assign agu_icb_rsp_valid = mem_icb_rsp_valid & ~empty;
   assign mem_icb_rsp_ready = agu_icb_rsp_ready & ~empty;
   assign agu_icb_rsp_err   = mem_icb_rsp_err;

   assign push       = agu_icb_cmd_valid & agu_icb_cmd_ready;
   assign pop        = agu_icb_rsp_valid & agu_icb_rsp_ready;
   assign outs_empty = empty;
   assign head       = ent_q[rptr_q];

   always_comb begin
      mem_icb_cmd_wdata = agu_icb_cmd_wdata;
      mem_icb_cmd_wmask = 4'b1111;
      case (agu_icb_cmd_size)
         2'd0: begin
            mem_icb_cmd_wdata = {4{agu_icb_cmd_wdata[7:0]}};
            mem_icb_cmd_wmask = 4'b0001 << agu_icb_cmd_addr[1:0];
         end
         2'd1: begin
            mem_icb_cmd_wdata = {2{agu_icb_cmd_wdata[15:0]}};
            mem_icb_cmd_wmask = agu_icb_cmd_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   logic [31:0] rsp_shift;
   logic        rsp_sbit;

   always_comb begin
      rsp_shift         = mem_icb_rsp_rdata >> {head.addr, 3'b000};
      rsp_sbit          = 1'b0;
      agu_icb_rsp_rdata = rsp_shift;
      case (head.size)
         2'd0: begin
            rsp_sbit          = ~head.usign & rsp_shift[7];
            agu_icb_rsp_rdata = {{24{rsp_sbit}}, rsp_shift[7:0]};
         end
         2'd1: begin
            rsp_sbit          = ~head.usign & rsp_shift[15];
            agu_icb_rsp_rdata = {{16{rsp_sbit}}, rsp_shift[15:0]};
         end
         default: ;
      endcase
      if (!head.read || mem_icb_rsp_err) begin
         agu_icb_rsp_rdata = '0;
      end
      agu_icb_rsp_itag = head.itag;
   end

   // Explicit wrap keeps non-power-of-two depths correct.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push) begin
         wptr_d = (wptr_q == PW'(OUTS_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      end
      if (pop) begin
         rptr_d = (rptr_q == PW'(OUTS_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         ent_q[wptr_q] <= '{addr:  agu_icb_cmd_addr[1:0],
                            size:  agu_icb_cmd_size,
                            usign: agu_icb_cmd_usign,
                            read:  agu_icb_cmd_read,
                            itag:  agu_icb_cmd_itag};
      end
   end

endmodule

// File: tb/tb_e203_lsu_agu_icb_align.sv
// Bench for e203_lsu_agu_icb_align: directed literal checks plus random traffic compared each
// cycle against a queue-based model of the outstanding transactions.
module tb_e203_lsu_agu_icb_align;

   localparam int D = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        agu_icb_cmd_valid, agu_icb_cmd_ready;
   logic [31:0] agu_icb_cmd_addr;
   logic        agu_icb_cmd_read;
   logic [31:0] agu_icb_cmd_wdata;
   logic [1:0]  agu_icb_cmd_size;
   logic        agu_icb_cmd_usign, agu_icb_cmd_itag;
   logic        agu_icb_rsp_valid, agu_icb_rsp_ready, agu_icb_rsp_err;
   logic [31:0] agu_icb_rsp_rdata;
   logic        agu_icb_rsp_itag;
   logic        mem_icb_cmd_valid, mem_icb_cmd_ready;
   logic [31:0] mem_icb_cmd_addr;
   logic        mem_icb_cmd_read;
   logic [31:0] mem_icb_cmd_wdata;
   logic [3:0]  mem_icb_cmd_wmask;
   logic        mem_icb_rsp_valid, mem_icb_rsp_ready, mem_icb_rsp_err;
   logic [31:0] mem_icb_rsp_rdata;
   logic        outs_empty;

   always #5 clk = ~clk;

   e203_lsu_agu_icb_align #(.OUTS_DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .agu_icb_cmd_valid(agu_icb_cmd_valid), .agu_icb_cmd_ready(agu_icb_cmd_ready),
      .agu_icb_cmd_addr(agu_icb_cmd_addr), .agu_icb_cmd_read(agu_icb_cmd_read),
      .agu_icb_cmd_wdata(agu_icb_cmd_wdata), .agu_icb_cmd_size(agu_icb_cmd_size),
      .agu_icb_cmd_usign(agu_icb_cmd_usign), .agu_icb_cmd_itag(agu_icb_cmd_itag),
      .agu_icb_rsp_valid(agu_icb_rsp_valid), .agu_icb_rsp_ready(agu_icb_rsp_ready),
      .agu_icb_rsp_err(agu_icb_rsp_err), .agu_icb_rsp_rdata(agu_icb_rsp_rdata),
      .agu_icb_rsp_itag(agu_icb_rsp_itag),
      .mem_icb_cmd_valid(mem_icb_cmd_valid), .mem_icb_cmd_ready(mem_icb_cmd_ready),
      .mem_icb_cmd_addr(mem_icb_cmd_addr), .mem_icb_cmd_read(mem_icb_cmd_read),
      .mem_icb_cmd_wdata(mem_icb_cmd_wdata), .mem_icb_cmd_wmask(mem_icb_cmd_wmask),
      .mem_icb_rsp_valid(mem_icb_rsp_valid), .mem_icb_rsp_ready(mem_icb_rsp_ready),
      .mem_icb_rsp_err(mem_icb_rsp_err), .mem_icb_rsp_rdata(mem_icb_rsp_rdata),
      .outs_empty(outs_empty)
   );

   typedef struct {
      logic [1:0] a;
      logic [1:0] sz;
      logic       us;
      logic       rd;
      logic       tag;
   } ent_t;

   ent_t q[$];
   int   n_vec  = 0;
   int   n_err  = 0;
   bit   chk_en = 0;

   task automatic cmp32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
      if (sz == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
      if (sz == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
      return w;
   endfunction

   function automatic logic [3:0] m_wmask(input logic [1:0] sz, input logic [1:0] a);
      int lane;
      lane = int'(a);
      if (sz == 2'd0) return 4'((1 << lane));
      if (sz == 2'd1) return (lane >= 2) ? 4'd12 : 4'd3;
      return 4'd15;
   endfunction

   function automatic logic [31:0] m_rdata(input ent_t e, input logic [31:0] raw, input logic err);
      logic [31:0] s;
      logic [31:0] v;
      if (!e.rd || err) return 32'd0;
      s = raw >> (8 * int'(e.a));
      if (e.sz == 2'd0) begin
         v = s & 32'hFF;
         if (!e.us && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end else if (e.sz == 2'd1) begin
         v = s & 32'hFFFF;
         if (!e.us && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end else begin
         v = s;
      end
      return v;
   endfunction

   // Model check and update: inputs are stable from posedge+1 until the next posedge.
   always @(negedge clk) begin
      bit   full, empty, do_push, do_pop;
      ent_t e;
      if (chk_en) begin
         full  = (q.size() == D);
         empty = (q.size() == 0);
         cmp1("mem_cmd_valid", mem_icb_cmd_valid, agu_icb_cmd_valid && !full);
         cmp1("agu_cmd_ready", agu_icb_cmd_ready, mem_icb_cmd_ready && !full);
         cmp32("mem_cmd_addr", mem_icb_cmd_addr, agu_icb_cmd_addr);
         cmp1("mem_cmd_read", mem_icb_cmd_read, agu_icb_cmd_read);
         cmp32("mem_cmd_wdata", mem_icb_cmd_wdata, m_wdata(agu_icb_cmd_size, agu_icb_cmd_wdata));
         cmp32("mem_cmd_wmask", 32'(mem_icb_cmd_wmask),
               32'(m_wmask(agu_icb_cmd_size, agu_icb_cmd_addr[1:0])));
         cmp1("agu_rsp_valid", agu_icb_rsp_valid, mem_icb_rsp_valid && !empty);
         cmp1("mem_rsp_ready", mem_icb_rsp_ready, agu_icb_rsp_ready && !empty);
         cmp1("outs_empty", outs_empty, empty);
         if (!empty && mem_icb_rsp_valid) begin
            cmp1("rsp_err", agu_icb_rsp_err, mem_icb_rsp_err);
            cmp1("rsp_itag", agu_icb_rsp_itag, q[0].tag);
            cmp32("rsp_rdata", agu_icb_rsp_rdata, m_rdata(q[0], mem_icb_rsp_rdata, mem_icb_rsp_err));
         end
         if (rst) begin
            q.delete();
         end else begin
            do_push = agu_icb_cmd_valid && mem_icb_cmd_ready && !full;
            do_pop  = mem_icb_rsp_valid && agu_icb_rsp_ready && !empty;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
               e.a   = agu_icb_cmd_addr[1:0];
               e.sz  = agu_icb_cmd_size;
               e.us  = agu_icb_cmd_usign;
               e.rd  = agu_icb_cmd_read;
               e.tag = agu_icb_cmd_itag;
               q.push_back(e);
            end
         end
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      agu_icb_cmd_valid = 1'b0;
      mem_icb_cmd_ready = 1'b1;
      mem_icb_rsp_valid = 1'b0;
      agu_icb_rsp_ready = 1'b1;
      mem_icb_rsp_err   = 1'b0;
   endtask

   task automatic issue(input logic [31:0] addr, input logic rd, input logic [31:0] wd,
                        input logic [1:0] sz, input logic us, input logic tag);
      agu_icb_cmd_valid = 1'b1;
      agu_icb_cmd_addr  = addr;
      agu_icb_cmd_read  = rd;
      agu_icb_cmd_wdata = wd;
      agu_icb_cmd_size  = sz;
      agu_icb_cmd_usign = us;
      agu_icb_cmd_itag  = tag;
   endtask

   task automatic respond(input string name, input logic [31:0] raw, input logic [31:0] exp_rd,
                          input logic exp_tag);
      idle();
      mem_icb_rsp_valid = 1'b1;
      mem_icb_rsp_rdata = raw;
      @(negedge clk);
      cmp1({name, "_valid"}, agu_icb_rsp_valid, 1'b1);
      cmp32({name, "_rdata"}, agu_icb_rsp_rdata, exp_rd);
      cmp1({name, "_itag"}, agu_icb_rsp_itag, exp_tag);
      next();
      idle();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      issue(32'h0, 1'b0, 32'h0, 2'd2, 1'b0, 1'b0);
      agu_icb_cmd_valid = 1'b0;
      mem_icb_rsp_rdata = 32'h0;
      next();
      chk_en = 1;
      mem_icb_rsp_valid = 1'b1;
      @(negedge clk);
      cmp1("rst_empty", outs_empty, 1'b1);
      cmp1("rst_rsp_ready", mem_icb_rsp_ready, 1'b0);
      cmp1("rst_rsp_valid", agu_icb_rsp_valid, 1'b0);
      next();
      rst = 1'b0;
      idle();

      issue(32'h100, 1'b0, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b1);
      @(negedge clk);
      cmp32("sw_wdata", mem_icb_cmd_wdata, 32'hDEAD_BEEF);
      cmp32("sw_wmask", 32'(mem_icb_cmd_wmask), 32'hF);
      cmp1("sw_ready", agu_icb_cmd_ready, 1'b1);
      next();
      respond("sw_rsp", 32'h1234_5678, 32'h0, 1'b1);
      @(negedge clk);
      cmp1("sw_empty", outs_empty, 1'b1);
      next();

      issue(32'h103, 1'b0, 32'h0000_00A5, 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      cmp32("sb_wdata", mem_icb_cmd_wdata, 32'hA5A5_A5A5);
      cmp32("sb_wmask", 32'(mem_icb_cmd_wmask), 32'h8);
      next();
      respond("sb_rsp", 32'hFFFF_FFFF, 32'h0, 1'b0);

      issue(32'h102, 1'b0, 32'h0000_1234, 2'd1, 1'b0, 1'b1);
      @(negedge clk);
      cmp32("sh_wdata", mem_icb_cmd_wdata, 32'h1234_1234);
      cmp32("sh_wmask", 32'(mem_icb_cmd_wmask), 32'hC);
      next();
      respond("sh_rsp", 32'h0, 32'h0, 1'b1);

      issue(32'h101, 1'b1, 32'h0, 2'd0, 1'b0, 1'b0);
      next();
      respond("lb", 32'h0000_8000, 32'hFFFF_FF80, 1'b0);
      issue(32'h101, 1'b1, 32'h0, 2'd0, 1'b1, 1'b1);
      next();
      respond("lbu", 32'h0000_8000, 32'h0000_0080, 1'b1);
      issue(32'h102, 1'b1, 32'h0, 2'd1, 1'b0, 1'b0);
      next();
      respond("lh", 32'h8001_0000, 32'hFFFF_8001, 1'b0);

      // Fill the tracker, then check the no-bypass rule when a pop coincides with a command.
      issue(32'h200, 1'b1, 32'h0, 2'd2, 1'b0, 1'b0);
      next();
      issue(32'h204, 1'b1, 32'h0, 2'd2, 1'b0, 1'b1);
      next();
      issue(32'h208, 1'b1, 32'h0, 2'd2, 1'b0, 1'b0);
      @(negedge clk);
      cmp1("full_block", agu_icb_cmd_ready, 1'b0);
      next();
      mem_icb_rsp_valid = 1'b1;
      mem_icb_rsp_rdata = 32'hAAAA_0001;
      @(negedge clk);
      cmp1("no_bypass", agu_icb_cmd_ready, 1'b0);
      cmp1("order0_itag", agu_icb_rsp_itag, 1'b0);
      cmp32("order0_rdata", agu_icb_rsp_rdata, 32'hAAAA_0001);
      next();
      mem_icb_rsp_valid = 1'b0;
      @(negedge clk);
      cmp1("accept_next", agu_icb_cmd_ready, 1'b1);
      next();
      idle();
      respond("order1", 32'h11, 32'h11, 1'b1);
      respond("order2", 32'h22, 32'h22, 1'b0);
      @(negedge clk);
      cmp1("drain_empty", outs_empty, 1'b1);
      next();

      issue(32'h300, 1'b1, 32'h0, 2'd2, 1'b0, 1'b1);
      next();
      issue(32'h304, 1'b1, 32'h0, 2'd2, 1'b0, 1'b0);
      next();
      idle();
      rst = 1'b1;
      next();
      rst = 1'b0;
      mem_icb_rsp_valid = 1'b1;
      @(negedge clk);
      cmp1("rst2_empty", outs_empty, 1'b1);
      cmp1("rst2_rsp_valid", agu_icb_rsp_valid, 1'b0);
      cmp1("rst2_rsp_ready", mem_icb_rsp_ready, 1'b0);
      next();
      idle();

      for (int i = 0; i < 3000; i++) begin
         agu_icb_cmd_valid = 1'($urandom_range(1));
         agu_icb_cmd_addr  = $urandom;
         agu_icb_cmd_read  = 1'($urandom_range(1));
         agu_icb_cmd_wdata = $urandom;
         agu_icb_cmd_size  = 2'($urandom_range(3));
         agu_icb_cmd_usign = 1'($urandom_range(1));
         agu_icb_cmd_itag  = 1'($urandom_range(1));
         mem_icb_cmd_ready = 1'($urandom_range(1));
         agu_icb_rsp_ready = 1'($urandom_range(1));
         mem_icb_rsp_valid = ($urandom_range(2) != 0);
         mem_icb_rsp_err   = ($urandom_range(7) == 0);
         mem_icb_rsp_rdata = $urandom;
         next();
      end

      idle();
      mem_icb_rsp_valid = 1'b1;
      mem_icb_rsp_rdata = 32'h0;
      repeat (D + 2) next();
      @(negedge clk);
      cmp1("final_empty", outs_empty, 1'b1);
      next();
      chk_en = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
